// File: rtl/pyc_fifo_pkg.sv
// Shared FIFO sizing helpers: ceiling log2, occupancy-counter width and pointer width.
package pyc_fifo_pkg;

  function automatic int pyc_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

  // count must represent 0..depth inclusive
  function automatic int pyc_cnt_w(input int depth);
    return pyc_clog2(depth + 1);
  endfunction

  function automatic int pyc_ptr_w(input int entries);
    return (entries <= 1) ? 1 : pyc_clog2(entries);
  endfunction

endpackage

// File: rtl/pyc_fifo_mem.sv
// Storage array behind the output register: one write port, asynchronous read.
module pyc_fifo_mem #(
  parameter int WIDTH   = 8,
  parameter int ENTRIES = 3,
  parameter int AW      = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/pyc_sync_fifo.sv
// Synchronous FIFO with registered output stage; all outputs come straight from flops.
// Define PYC_SYNC_FIFO_WATERMARK_EN to add the max_count high-water-mark output.
module pyc_sync_fifo import pyc_fifo_pkg::*; #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int AFULL_LVL  = DEPTH - 1,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  output logic [pyc_cnt_w(DEPTH)-1:0] count,
  output logic                       almost_full,
  output logic                       almost_empty
`ifdef PYC_SYNC_FIFO_WATERMARK_EN
  ,
  output logic [pyc_cnt_w(DEPTH)-1:0] max_count
`endif
);

  localparam int CW = pyc_cnt_w(DEPTH);
  localparam int SE = DEPTH - 1;
  localparam int PW = pyc_ptr_w(SE);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AE_C   = CW'(AEMPTY_LVL);
  localparam logic [PW-1:0] LAST_P = PW'(SE - 1);

`ifndef SYNTHESIS
  initial begin
    if (DEPTH < 2 || AFULL_LVL > DEPTH || AEMPTY_LVL >= DEPTH) begin
      $error("pyc_sync_fifo: bad parameters DEPTH=%0d AFULL_LVL=%0d AEMPTY_LVL=%0d",
             DEPTH, AFULL_LVL, AEMPTY_LVL);
      $finish;
    end
  end
`endif

  // explicit compare so non-power-of-two storage wraps correctly
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             ov_nxt;
  logic [WIDTH-1:0] od_nxt, sto_rdata;
  logic             push, pop, sto_empty, out_load, bypass, sto_wr, sto_rd;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // storage occupancy is count minus the output register
  assign sto_empty = (count == CW'(out_valid));
  assign out_load  = ~out_valid | pop;
  assign sto_rd    = out_load & ~sto_empty;
  assign bypass    = out_load & sto_empty & push;
  assign sto_wr    = push & ~bypass & ~flush;

  always_comb begin
    wr_ptr_nxt = sto_wr ? ptr_inc(wr_ptr) : wr_ptr;
    rd_ptr_nxt = sto_rd ? ptr_inc(rd_ptr) : rd_ptr;
    ov_nxt     = out_valid;
    od_nxt     = out_data;
    if (out_load) begin
      if (!sto_empty) begin
        ov_nxt = 1'b1;
        od_nxt = sto_rdata;
      end else if (push) begin
        ov_nxt = 1'b1;
        od_nxt = in_data;
      end else begin
        ov_nxt = 1'b0;
        od_nxt = '0;
      end
    end
    cnt_nxt = count;
    if (push && !pop)      cnt_nxt = count + 1'b1;
    else if (pop && !push) cnt_nxt = count - 1'b1;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      ov_nxt     = 1'b0;
      od_nxt     = '0;
      cnt_nxt    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      in_ready     <= 1'b1;
      almost_full  <= (AFULL_LVL == 0);
      almost_empty <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= cnt_nxt;
      out_valid    <= ov_nxt;
      out_data     <= od_nxt;
      in_ready     <= (cnt_nxt != FULL_C);
      almost_full  <= (cnt_nxt >= AF_C);
      almost_empty <= (cnt_nxt <= AE_C);
    end
  end

`ifdef PYC_SYNC_FIFO_WATERMARK_EN
  always_ff @(posedge clk) begin
    if (rst || flush)          max_count <= '0;
    else if (cnt_nxt > max_count) max_count <= cnt_nxt;
  end
`endif

  pyc_fifo_mem #(
    .WIDTH   (WIDTH),
    .ENTRIES (SE),
    .AW      (PW)
  ) u_mem (
    .clk   (clk),
    .we    (sto_wr),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (sto_rdata)
  );

endmodule

// File: tb/tb_pyc_sync_fifo.sv
// Directed bench for pyc_sync_fifo: three depths (3, 4, 5) share one input stimulus bundle.
module tb_pyc_sync_fifo;

  logic       clk = 1'b0;
  logic       rst, iv, ordy, fl;
  logic [7:0] id;

  logic       ir3, ov3, af3, ae3;
  logic [7:0] od3;
  logic [1:0] c3;
  logic       ir4, ov4, af4, ae4;
  logic [7:0] od4;
  logic [2:0] c4;
  logic       ir5, ov5, af5, ae5;
  logic [7:0] od5;
  logic [2:0] c5;
`ifdef PYC_SYNC_FIFO_WATERMARK_EN
  logic [1:0] m3;
  logic [2:0] m4, m5;
`endif

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pyc_sync_fifo #(.WIDTH(8), .DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir3), .in_data(id),
    .out_valid(ov3), .out_ready(ordy), .out_data(od3), .flush(fl),
    .count(c3), .almost_full(af3), .almost_empty(ae3)
`ifdef PYC_SYNC_FIFO_WATERMARK_EN
    , .max_count(m3)
`endif
  );

  pyc_sync_fifo #(.WIDTH(8), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir4), .in_data(id),
    .out_valid(ov4), .out_ready(ordy), .out_data(od4), .flush(fl),
    .count(c4), .almost_full(af4), .almost_empty(ae4)
`ifdef PYC_SYNC_FIFO_WATERMARK_EN
    , .max_count(m4)
`endif
  );

  pyc_sync_fifo #(.WIDTH(8), .DEPTH(5)) u5 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir5), .in_data(id),
    .out_valid(ov5), .out_ready(ordy), .out_data(od5), .flush(fl),
    .count(c5), .almost_full(af5), .almost_empty(ae5)
`ifdef PYC_SYNC_FIFO_WATERMARK_EN
    , .max_count(m5)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic f);
    iv = v; id = d; ordy = r; fl = f;
  endtask

  task automatic do_rst;
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    // reset state on all three depths
    do_rst();
    chk("rst_ir3", ir3, 1); chk("rst_ov3", ov3, 0); chk("rst_od3", od3, 0);
    chk("rst_c3", c3, 0);   chk("rst_af3", af3, 0); chk("rst_ae3", ae3, 1);
    chk("rst_ir4", ir4, 1); chk("rst_ov4", ov4, 0); chk("rst_od4", od4, 0);
    chk("rst_c4", c4, 0);   chk("rst_af4", af4, 0); chk("rst_ae4", ae4, 1);
    chk("rst_ir5", ir5, 1); chk("rst_ov5", ov5, 0); chk("rst_od5", od5, 0);
    chk("rst_c5", c5, 0);   chk("rst_af5", af5, 0); chk("rst_ae5", ae5, 1);
`ifdef PYC_SYNC_FIFO_WATERMARK_EN
    chk("rst_m3", m3, 0); chk("rst_m4", m4, 0); chk("rst_m5", m5, 0);
`endif

    // DEPTH=3 fill with sink stalled
    drive(1, 8'h11, 0, 0); step();
    chk("d3_first_ov", ov3, 1); chk("d3_first_od", od3, 8'h11); chk("d3_first_c", c3, 1);
    drive(1, 8'h22, 0, 0); step();
    drive(1, 8'h33, 0, 0); step();
    chk("d3_full_ir", ir3, 0); chk("d3_full_c", c3, 3);
    chk("d3_full_od", od3, 8'h11); chk("d3_full_af", af3, 1);
    drive(1, 8'h44, 0, 0); step();
    chk("d3_hold_c", c3, 3); chk("d3_hold_od", od3, 8'h11);
    drive(0, 8'h00, 1, 0); step();
    chk("d3_pop1", od3, 8'h22);
    step();
    chk("d3_pop2", od3, 8'h33);
    step();
    chk("d3_empty_ov", ov3, 0); chk("d3_empty_od", od3, 0); chk("d3_empty_c", c3, 0);

    // DEPTH=4 single-word latency
    do_rst();
    drive(1, 8'hA5, 0, 0); step();
    chk("lat_ov", ov4, 1); chk("lat_od", od4, 8'hA5); chk("lat_c", c4, 1); chk("lat_ae", ae4, 1);
    drive(0, 8'h00, 1, 0); step();
    chk("lat_pop_ov", ov4, 0); chk("lat_pop_od", od4, 0); chk("lat_pop_c", c4, 0);

    // DEPTH=5 continuous stream through an empty FIFO
    do_rst();
    for (int k = 0; k < 20; k++) begin
      drive(1, 8'(k), 1, 0); step();
      chk("strm_od", od5, k); chk("strm_c", c5, 1); chk("strm_ov", ov5, 1);
    end
    drive(0, 8'h00, 1, 0); step();
    chk("strm_end_ov", ov5, 0); chk("strm_end_c", c5, 0);

    // DEPTH=5 stream with a two-word backlog so storage pointers wrap
    do_rst();
    drive(1, 8'd40, 0, 0); step();
    drive(1, 8'd41, 0, 0); step();
    chk("bklg_c", c5, 2); chk("bklg_od", od5, 40);
    for (int i = 2; i < 20; i++) begin
      drive(1, 8'(40 + i), 1, 0); step();
      chk("wrap_od", od5, 40 + i - 1); chk("wrap_c", c5, 2);
    end
    drive(0, 8'h00, 1, 0); step();
    chk("wrap_tail_od", od5, 59); chk("wrap_tail_c", c5, 1);
    step();
    chk("wrap_end_ov", ov5, 0); chk("wrap_end_c", c5, 0);

    // DEPTH=4 full: pop with in_valid high must not push
    do_rst();
    for (int k = 1; k <= 4; k++) begin
      drive(1, 8'(k), 0, 0); step();
    end
    chk("full_ir", ir4, 0); chk("full_c", c4, 4); chk("full_af", af4, 1); chk("full_ae", ae4, 0);
    drive(1, 8'd5, 1, 0); step();
    chk("fpop_c", c4, 3); chk("fpop_od", od4, 2); chk("fpop_ir", ir4, 1); chk("fpop_af", af4, 1);
    drive(1, 8'd6, 0, 0); step();
    chk("refill_c", c4, 4); chk("refill_ir", ir4, 0);
    drive(0, 8'h00, 1, 0); step();
    chk("dr1_od", od4, 3); chk("dr1_c", c4, 3);
    step();
    chk("dr2_od", od4, 4);
    step();
    chk("dr3_od", od4, 6); chk("dr3_ae", ae4, 1);
    step();
    chk("dr4_ov", ov4, 0); chk("dr4_od", od4, 0); chk("dr4_c", c4, 0);

    // flush drops contents and the word presented alongside it
    do_rst();
    drive(1, 8'h10, 0, 0); step();
    drive(1, 8'h20, 0, 0); step();
    chk("pre_fl_c", c4, 2); chk("pre_fl_ae", ae4, 0);
    drive(1, 8'h99, 1, 1); step();
    chk("fl_c", c4, 0); chk("fl_ov", ov4, 0); chk("fl_ae", ae4, 1);
    chk("fl_od", od4, 0); chk("fl_ir", ir4, 1);
    drive(0, 8'h00, 1, 0); step();
    chk("post_fl_ov", ov4, 0); chk("post_fl_c", c4, 0);
    drive(1, 8'h77, 1, 0); step();
    chk("post_fl_push_od", od4, 8'h77); chk("post_fl_push_c", c4, 1);
    drive(0, 8'h00, 1, 0); step();
    chk("post_fl_pop_ov", ov4, 0);

    // reset wins over a concurrent push mid-stream
    drive(1, 8'h33, 0, 0); step(); step();
    chk("pre_rst_c", c4, 2);
    rst = 1'b1; drive(1, 8'h44, 1, 0); step(); rst = 1'b0;
    chk("mid_rst_c", c4, 0); chk("mid_rst_ov", ov4, 0); chk("mid_rst_od", od4, 0);
    drive(0, 8'h00, 0, 0); step();
    chk("mid_rst_idle_ov", ov4, 0);

`ifdef PYC_SYNC_FIFO_WATERMARK_EN
    do_rst();
    for (int k = 0; k < 3; k++) begin
      drive(1, 8'(k + 1), 0, 0); step();
    end
    chk("wm_fill_c", c4, 3); chk("wm_fill_m", m4, 3);
    drive(0, 8'h00, 1, 0);
    step(); step(); step();
    chk("wm_drain_c", c4, 0); chk("wm_drain_m", m4, 3);
    do_rst();
    chk("wm_rst_m", m4, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
